// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory request/response bundle for the fetch front-end.
// Handshake: a request transfers on a clock edge where imem_req && imem_ready; the master
// holds imem_addr stable while imem_req is high and imem_ready is low. Exactly one imem_rvalid
// pulse returns per accepted request, in order, and there is no backpressure on responses.
interface fetch_prefetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Fetch front-end: issues one word fetch at a time and buffers returned words with their PC
// in a small FIFO whose head feeds the IF/ID register. Redirects flush the queue and any in-flight word.
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'h1,
    localparam int         PTR_W    = $clog2(DEPTH),
    localparam int         CNT_W    = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load_en,
    input  logic [31:0]           pc_next,
    fetch_prefetch_queue_if.master imem,
    output logic [31:0]           current_instruction,
    output logic [31:0]           current_pc,
    output logic                  instr_valid,
    output logic [1:0]            dbg_state,
    output logic [CNT_W-1:0]      dbg_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_fetch_pc;
    logic [31:0]       r_req_pc;
    logic [31:0]       r_fifo_instr [DEPTH];
    logic [31:0]       r_fifo_pc    [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_not_empty;
    logic w_issue;
    logic w_handshake;
    logic w_push;
    logic w_pop;

    // Only IDLE issues, so count < DEPTH already reserves a slot for the outstanding word.
    always_comb begin
        w_not_empty = (r_count != '0);
        w_issue     = (r_state == S_IDLE) && (r_count < FULL_COUNT) && !load_en && !reset;
        w_handshake = w_issue && imem.imem_ready;
        w_push      = (r_state == S_WAIT) && imem.imem_rvalid && !load_en;
        w_pop       = w_not_empty && en && !load_en;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_handshake) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem.imem_rvalid)  w_state_next = S_IDLE;
                else if (load_en)      w_state_next = S_DISCARD;
            end
            S_DISCARD: begin
                if (imem.imem_rvalid)  w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
        end else if (load_en) begin
            r_fetch_pc <= pc_next;
        end else if (w_handshake) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || load_en) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= imem.imem_rdata;
            r_fifo_pc[r_wr_ptr]    <= r_req_pc;
        end
    end

    assign imem.imem_req  = w_issue;
    assign imem.imem_addr = r_fetch_pc;

    assign instr_valid         = w_not_empty;
    assign current_instruction = w_not_empty ? r_fifo_instr[r_rd_ptr] : 32'h0;
    assign current_pc          = w_not_empty ? r_fifo_pc[r_rd_ptr]    : 32'h0;

    assign dbg_state = r_state;
    assign dbg_count = r_count;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: a word at address a is a+0x100 whenever the
// bench memory answers automatically with one-cycle latency.
module tb_fetch_prefetch_queue;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        load_en;
    logic [31:0] pc_next;
    logic [31:0] current_instruction;
    logic [31:0] current_pc;
    logic        instr_valid;
    logic [1:0]  dbg_state;
    logic [2:0]  dbg_count;

    int errors = 0;
    int checks = 0;
    bit auto_mem;

    always #5 clk = ~clk;

    fetch_prefetch_queue_if imem();

    fetch_prefetch_queue dut (
        .clk                 (clk),
        .reset               (reset),
        .en                  (en),
        .load_en             (load_en),
        .pc_next             (pc_next),
        .imem                (imem),
        .current_instruction (current_instruction),
        .current_pc          (current_pc),
        .instr_valid         (instr_valid),
        .dbg_state           (dbg_state),
        .dbg_count           (dbg_count)
    );

    // One clock cycle; in auto mode a handshake seen this cycle answers in the next.
    task automatic step();
        logic        hs;
        logic [31:0] a;
        #1;
        hs = imem.imem_req && imem.imem_ready;
        a  = imem.imem_addr;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem.imem_rvalid = hs;
            imem.imem_rdata  = a + 32'h100;
        end
        #1;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        en               = 1'b1;
        load_en          = 1'b0;
        pc_next          = 32'h0;
        auto_mem         = 1'b0;
        imem.imem_ready  = 1'b1;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'h0;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        step();
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", imem.imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", instr_valid); end
        checks++; if (current_instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", current_instruction); end
        checks++; if (current_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", current_pc); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        checks++; if (dbg_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", dbg_count); end
        reset = 1'b0;
        #1;
        checks++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL post_reset_req got=%0b exp=1", imem.imem_req); end
        checks++; if (imem.imem_addr !== 32'h0) begin errors++; $display("FAIL post_reset_addr got=%h exp=0", imem.imem_addr); end
    endtask

    task automatic test_sequential();
        int          first_hs = -1;
        int          first_v  = -1;
        logic [31:0] exp_pc   = 32'h0;
        do_reset();
        auto_mem = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (first_hs < 0 && imem.imem_req && imem.imem_ready) first_hs = i;
            if (instr_valid) begin
                if (first_v < 0) first_v = i;
                checks++; if (current_pc !== exp_pc) begin errors++; $display("FAIL seq_pc got=%h exp=%h", current_pc, exp_pc); end
                checks++; if (current_instruction !== exp_pc + 32'h100) begin errors++; $display("FAIL seq_instr got=%h exp=%h", current_instruction, exp_pc + 32'h100); end
                exp_pc++;
            end
            step();
        end
        checks++; if (first_v - first_hs !== 2) begin errors++; $display("FAIL seq_latency got=%0d exp=2", first_v - first_hs); end
        checks++; if (exp_pc < 32'd8) begin errors++; $display("FAIL seq_heads got=%0d exp>=8", exp_pc); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc = 32'h0;
        do_reset();
        auto_mem = 1'b1;
        en       = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i >= 8) begin
                checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_full cyc=%0d got=%0b exp=0", i, imem.imem_req); end
            end
        end
        checks++; if (dbg_count !== 3'd4) begin errors++; $display("FAIL stall_count got=%0d exp=4", dbg_count); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got=%0b exp=1", instr_valid); end
        checks++; if (current_pc !== 32'h0) begin errors++; $display("FAIL stall_head_pc got=%h exp=0", current_pc); end
        checks++; if (current_instruction !== 32'h100) begin errors++; $display("FAIL stall_head_instr got=%h exp=100", current_instruction); end
        en = 1'b1;
        #1;
        for (int i = 0; i < 40 && exp_pc < 32'd8; i++) begin
            if (instr_valid) begin
                checks++; if (current_pc !== exp_pc) begin errors++; $display("FAIL drain_pc got=%h exp=%h", current_pc, exp_pc); end
                exp_pc++;
            end
            step();
        end
        checks++; if (exp_pc !== 32'd8) begin errors++; $display("FAIL drain_timeout got=%0d exp=8", exp_pc); end
    endtask

    task automatic test_redirect_wait();
        bit found = 1'b0;
        do_reset();
        step();
        checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL rw_state_wait got=%0d exp=%0d", dbg_state, ST_WAIT); end
        load_en = 1'b1;
        pc_next = 32'h40;
        #1;
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rw_req_redirect got=%0b exp=0", imem.imem_req); end
        step();
        load_en = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'hDEAD_0000;
        #1;
        checks++; if (dbg_state !== ST_DISCARD) begin errors++; $display("FAIL rw_state_discard got=%0d exp=%0d", dbg_state, ST_DISCARD); end
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rw_req_discard got=%0b exp=0", imem.imem_req); end
        step();
        imem.imem_rvalid = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rw_stale_valid got=%0b exp=0", instr_valid); end
        checks++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL rw_req_after got=%0b exp=1", imem.imem_req); end
        checks++; if (imem.imem_addr !== 32'h40) begin errors++; $display("FAIL rw_addr got=%h exp=40", imem.imem_addr); end
        auto_mem = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
            if (instr_valid) found = 1'b1;
            else step();
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL rw_head_timeout got=none exp=pc 40");
        end else begin
            checks++; if (current_pc !== 32'h40) begin errors++; $display("FAIL rw_head_pc got=%h exp=40", current_pc); end
            checks++; if (current_instruction !== 32'h140) begin errors++; $display("FAIL rw_head_instr got=%h exp=140", current_instruction); end
        end
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        step();
        load_en = 1'b1;
        pc_next = 32'h80;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'hBEEF;
        #1;
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rr_req_redirect got=%0b exp=0", imem.imem_req); end
        step();
        load_en = 1'b0;
        imem.imem_rvalid = 1'b0;
        #1;
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rr_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rr_valid got=%0b exp=0", instr_valid); end
        checks++; if (dbg_count !== 3'd0) begin errors++; $display("FAIL rr_count got=%0d exp=0", dbg_count); end
        checks++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL rr_req got=%0b exp=1", imem.imem_req); end
        checks++; if (imem.imem_addr !== 32'h80) begin errors++; $display("FAIL rr_addr got=%h exp=80", imem.imem_addr); end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        auto_mem = 1'b1;
        en       = 1'b0;
        for (int i = 0; i < 10; i++) step();
        checks++; if (dbg_count !== 3'd4) begin errors++; $display("FAIL rf_full_count got=%0d exp=4", dbg_count); end
        load_en = 1'b1;
        pc_next = 32'h200;
        #1;
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rf_req_redirect got=%0b exp=0", imem.imem_req); end
        step();
        load_en = 1'b0;
        #1;
        checks++; if (dbg_count !== 3'd0) begin errors++; $display("FAIL rf_count got=%0d exp=0", dbg_count); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rf_valid got=%0b exp=0", instr_valid); end
        checks++; if (current_instruction !== 32'h0) begin errors++; $display("FAIL rf_bubble got=%h exp=0", current_instruction); end
        checks++; if (imem.imem_addr !== 32'h200) begin errors++; $display("FAIL rf_addr got=%h exp=200", imem.imem_addr); end
        checks++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL rf_req got=%0b exp=1", imem.imem_req); end
    endtask

    task automatic test_ready_stall();
        do_reset();
        auto_mem        = 1'b1;
        imem.imem_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL rs_req cyc=%0d got=%0b exp=1", i, imem.imem_req); end
            checks++; if (imem.imem_addr !== 32'h0) begin errors++; $display("FAIL rs_addr cyc=%0d got=%h exp=0", i, imem.imem_addr); end
            step();
        end
        imem.imem_ready = 1'b1;
        step();
        checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL rs_state got=%0d exp=%0d", dbg_state, ST_WAIT); end
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rs_req_wait got=%0b exp=0", imem.imem_req); end
        step();
        checks++; if (current_pc !== 32'h0 || instr_valid !== 1'b1) begin errors++; $display("FAIL rs_head got=%h/%0b exp=0/1", current_pc, instr_valid); end
        checks++; if (current_instruction !== 32'h100) begin errors++; $display("FAIL rs_instr got=%h exp=100", current_instruction); end
        checks++; if (imem.imem_addr !== 32'h1) begin errors++; $display("FAIL rs_next_addr got=%h exp=1", imem.imem_addr); end
    endtask

    task automatic test_reset_wait();
        bit found = 1'b0;
        do_reset();
        step();
        checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL rst_w_state got=%0d exp=%0d", dbg_state, ST_WAIT); end
        reset           = 1'b1;
        imem.imem_ready = 1'b0;
        step();
        reset = 1'b0;
        #1;
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_w_idle got=%0d exp=%0d", dbg_state, ST_IDLE); end
        checks++; if (imem.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_w_addr got=%h exp=0", imem.imem_addr); end
        step();
        step();
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'hBAD;
        step();
        imem.imem_rvalid = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_w_late_valid got=%0b exp=0", instr_valid); end
        checks++; if (dbg_count !== 3'd0) begin errors++; $display("FAIL rst_w_count got=%0d exp=0", dbg_count); end
        checks++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL rst_w_req got=%0b exp=1", imem.imem_req); end
        imem.imem_ready = 1'b1;
        auto_mem        = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
            if (instr_valid) found = 1'b1;
            else step();
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL rst_w_head_timeout got=none exp=pc 0");
        end else begin
            checks++; if (current_pc !== 32'h0) begin errors++; $display("FAIL rst_w_head_pc got=%h exp=0", current_pc); end
            checks++; if (current_instruction !== 32'h100) begin errors++; $display("FAIL rst_w_head_instr got=%h exp=100", current_instruction); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_redirect_flush();
        test_ready_stall();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
